// File: rtl/hash_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hash_request_sequencer
// Description : Front-end stage in front of the hash table controller.
//               Accepts one read/write/delete request at a time, latches it,
//               drives the key to the external hash unit, issues the table
//               read, waits READ_LATENCY cycles, presents the operation to the
//               controller for a single evaluation cycle, then holds the
//               result as a response until it is accepted. Also keeps a
//               saturating count of stored elements.
//
// Ports:
//   clk, reset                 clock (rising edge) / synchronous active-high reset
//   req_valid_i/req_ready_o    request handshake
//   req_op_i                   00 nop, 01 read, 10 write, 11 delete
//   req_key_i, req_data_i      request key / write data
//   hash_key_o                 latched key driven to the hash unit
//   hash_adr_i                 per-table hash of hash_key_o (combinational)
//   tbl_rd_en_o, tbl_rd_adr_o  table read strobe / addresses
//   ctrl_key_o, ctrl_data_o    latched key / data to the controller
//   ctrl_op_o                  op to the controller (non-zero only in EVAL)
//   ctrl_hash_adr_o            registered hash addresses to the controller
//   ctrl_read_data_i           controller read data
//   ctrl_no_*_i, ctrl_key_already_present_i   controller status flags
//   resp_valid_o/resp_ready_i  response handshake
//   resp_data_o, resp_status_o held response (status: 000 ok, 001 not found,
//                              010 no deletion target, 011 no write space,
//                              100 key present)
//   element_count_o            number of stored elements
//
// Revision    : 1.0  initial release
// ============================================================================
module hash_request_sequencer #(
  parameter int unsigned KEY_WIDTH           = 2,
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned NUMBER_OF_TABLES    = 3,
  parameter int unsigned HASH_TABLE_MAX_SIZE = 2,
  parameter int unsigned READ_LATENCY        = 1,
  parameter int unsigned COUNT_WIDTH         = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          req_valid_i,
  output logic                                          req_ready_o,
  input  logic [1:0]                                    req_op_i,
  input  logic [KEY_WIDTH-1:0]                          req_key_i,
  input  logic [DATA_WIDTH-1:0]                         req_data_i,
  output logic [KEY_WIDTH-1:0]                          hash_key_o,
  input  logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] hash_adr_i,
  output logic                                          tbl_rd_en_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] tbl_rd_adr_o,
  output logic [KEY_WIDTH-1:0]                          ctrl_key_o,
  output logic [DATA_WIDTH-1:0]                         ctrl_data_o,
  output logic [1:0]                                    ctrl_op_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] ctrl_hash_adr_o,
  input  logic [DATA_WIDTH-1:0]                         ctrl_read_data_i,
  input  logic                                          ctrl_no_element_found_i,
  input  logic                                          ctrl_no_deletion_target_i,
  input  logic                                          ctrl_no_write_space_i,
  input  logic                                          ctrl_key_already_present_i,
  output logic                                          resp_valid_o,
  input  logic                                          resp_ready_i,
  output logic [DATA_WIDTH-1:0]                         resp_data_o,
  output logic [2:0]                                    resp_status_o,
  output logic [COUNT_WIDTH-1:0]                        element_count_o
);

  localparam int unsigned c_ADR_W = HASH_TABLE_MAX_SIZE * NUMBER_OF_TABLES;
  // Down-counter spans READ_LATENCY-1 .. 0; keep at least one bit.
  localparam int unsigned c_CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [c_CNT_W-1:0]     c_RD_LOAD   = c_CNT_W'(READ_LATENCY - 1);
  localparam logic [COUNT_WIDTH-1:0] c_COUNT_MAX = '1;

  localparam logic [1:0] c_OP_NOP   = 2'b00;
  localparam logic [1:0] c_OP_READ  = 2'b01;
  localparam logic [1:0] c_OP_WRITE = 2'b10;
  localparam logic [1:0] c_OP_DEL   = 2'b11;

  localparam logic [2:0] c_ST_OK       = 3'b000;
  localparam logic [2:0] c_ST_NOTFOUND = 3'b001;
  localparam logic [2:0] c_ST_NODEL    = 3'b010;
  localparam logic [2:0] c_ST_NOSPACE  = 3'b011;
  localparam logic [2:0] c_ST_PRESENT  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EVAL = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [c_CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [1:0]              op_q, op_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    req_ready_q, req_ready_d;
  logic                    tbl_rd_en_q, tbl_rd_en_d;
  logic [c_ADR_W-1:0]      hash_adr_q, hash_adr_d;
  logic [1:0]              ctrl_op_q, ctrl_op_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [2:0]              resp_status_q, resp_status_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;

  logic [2:0]              w_status;

  // Controller status with fixed priority; only consumed during EVAL.
  always_comb begin
    w_status = c_ST_OK;
    if (ctrl_key_already_present_i) begin
      w_status = c_ST_PRESENT;
    end else if (ctrl_no_write_space_i) begin
      w_status = c_ST_NOSPACE;
    end else if (ctrl_no_deletion_target_i) begin
      w_status = c_ST_NODEL;
    end else if (ctrl_no_element_found_i) begin
      w_status = c_ST_NOTFOUND;
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    op_d          = op_q;
    key_d         = key_q;
    data_d        = data_q;
    hash_adr_d    = hash_adr_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    count_d       = count_q;
    // Single-cycle strobes default low.
    tbl_rd_en_d   = 1'b0;
    ctrl_op_d     = c_OP_NOP;

    case (state_q)
      ST_IDLE: begin
        // A nop handshake is simply consumed and leaves everything as is.
        if (req_valid_i && req_ready_q && (req_op_i != c_OP_NOP)) begin
          op_d        = req_op_i;
          key_d       = req_key_i;
          data_d      = req_data_i;
          rd_cnt_d    = c_RD_LOAD;
          // Strobe lines up with the first READ cycle.
          tbl_rd_en_d = 1'b1;
          state_d     = ST_READ;
        end
      end

      ST_READ: begin
        // The hash unit sees the latched key from the first READ cycle on,
        // so that is when its result is captured for the controller.
        if (tbl_rd_en_q) begin
          hash_adr_d = hash_adr_i;
        end
        if (rd_cnt_q == '0) begin
          // ctrl_op is registered, so load it here to be live during EVAL.
          ctrl_op_d = op_q;
          state_d   = ST_EVAL;
        end else begin
          rd_cnt_d = rd_cnt_q - c_CNT_W'(1);
        end
      end

      ST_EVAL: begin
        resp_status_d = w_status;
        if ((op_q == c_OP_READ) && !ctrl_no_element_found_i) begin
          resp_data_d = ctrl_read_data_i;
        end else begin
          resp_data_d = '0;
        end
        if ((op_q == c_OP_WRITE) && (w_status == c_ST_OK) && (count_q != c_COUNT_MAX)) begin
          count_d = count_q + COUNT_WIDTH'(1);
        end else if ((op_q == c_OP_DEL) && (w_status == c_ST_OK) && (count_q != '0)) begin
          count_d = count_q - COUNT_WIDTH'(1);
        end
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        // Data and status stay held; only valid drops on the handshake.
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered ready follows the next state, so it is high exactly in IDLE
    // (apart from the first cycle after reset, where every output is 0).
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rd_cnt_q      <= '0;
      op_q          <= '0;
      key_q         <= '0;
      data_q        <= '0;
      req_ready_q   <= 1'b0;
      tbl_rd_en_q   <= 1'b0;
      hash_adr_q    <= '0;
      ctrl_op_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      op_q          <= op_d;
      key_q         <= key_d;
      data_q        <= data_d;
      req_ready_q   <= req_ready_d;
      tbl_rd_en_q   <= tbl_rd_en_d;
      hash_adr_q    <= hash_adr_d;
      ctrl_op_q     <= ctrl_op_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      count_q       <= count_d;
    end
  end

  assign req_ready_o     = req_ready_q;
  assign hash_key_o      = key_q;
  assign ctrl_key_o      = key_q;
  assign ctrl_data_o     = data_q;
  assign tbl_rd_en_o     = tbl_rd_en_q;
  // First READ cycle passes the live hash through; afterwards the captured
  // copy holds the address steady.
  assign tbl_rd_adr_o    = tbl_rd_en_q ? hash_adr_i : hash_adr_q;
  assign ctrl_hash_adr_o = hash_adr_q;
  assign ctrl_op_o       = ctrl_op_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;
  assign resp_status_o   = resp_status_q;
  assign element_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_request_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hash_request_sequencer
// Description : Self-checking bench. Two instances: d0 (READ_LATENCY=1,
//               COUNT_WIDTH=8) and d1 (READ_LATENCY=3, COUNT_WIDTH=3).
//               A transaction-level model tracks each request by its age in
//               cycles since acceptance and predicts every output each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hash_request_sequencer;

  localparam int KW = 2;
  localparam int DW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst[2];
  logic            req_valid[2];
  logic            req_ready[2];
  logic [1:0]      req_op[2];
  logic [KW-1:0]   req_key[2];
  logic [DW-1:0]   req_data[2];
  logic [KW-1:0]   hkey[2];
  logic [AW-1:0]   hadr[2];
  logic            rd_en[2];
  logic [AW-1:0]   rd_adr[2];
  logic [KW-1:0]   ckey[2];
  logic [DW-1:0]   cdata[2];
  logic [1:0]      cop[2];
  logic [AW-1:0]   chadr[2];
  logic [DW-1:0]   rdata_i[2];
  logic            nf[2], nd[2], nws[2], kp[2];
  logic            rvalid[2];
  logic            rready[2];
  logic [DW-1:0]   rdata_o[2];
  logic [2:0]      rstat[2];
  logic [7:0]      cnt0;
  logic [2:0]      cnt1;

  int checks = 0;
  int failures = 0;

  // Simple per-table hash: table t maps key to key*(t+1)+t modulo 4.
  function automatic logic [AW-1:0] hashf(input logic [KW-1:0] key);
    logic [AW-1:0] r;
    r = '0;
    for (int t = 0; t < 3; t++) begin
      r[t*2 +: 2] = 2'(key * (t + 1) + t);
    end
    return r;
  endfunction

  assign hadr[0] = hashf(hkey[0]);
  assign hadr[1] = hashf(hkey[1]);

  hash_request_sequencer #(
    .KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUMBER_OF_TABLES(3),
    .HASH_TABLE_MAX_SIZE(2), .READ_LATENCY(1), .COUNT_WIDTH(8)
  ) dut0 (
    .clk(clk), .reset(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_op_i(req_op[0]), .req_key_i(req_key[0]), .req_data_i(req_data[0]),
    .hash_key_o(hkey[0]), .hash_adr_i(hadr[0]),
    .tbl_rd_en_o(rd_en[0]), .tbl_rd_adr_o(rd_adr[0]),
    .ctrl_key_o(ckey[0]), .ctrl_data_o(cdata[0]), .ctrl_op_o(cop[0]),
    .ctrl_hash_adr_o(chadr[0]), .ctrl_read_data_i(rdata_i[0]),
    .ctrl_no_element_found_i(nf[0]), .ctrl_no_deletion_target_i(nd[0]),
    .ctrl_no_write_space_i(nws[0]), .ctrl_key_already_present_i(kp[0]),
    .resp_valid_o(rvalid[0]), .resp_ready_i(rready[0]),
    .resp_data_o(rdata_o[0]), .resp_status_o(rstat[0]),
    .element_count_o(cnt0)
  );

  hash_request_sequencer #(
    .KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUMBER_OF_TABLES(3),
    .HASH_TABLE_MAX_SIZE(2), .READ_LATENCY(3), .COUNT_WIDTH(3)
  ) dut1 (
    .clk(clk), .reset(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_op_i(req_op[1]), .req_key_i(req_key[1]), .req_data_i(req_data[1]),
    .hash_key_o(hkey[1]), .hash_adr_i(hadr[1]),
    .tbl_rd_en_o(rd_en[1]), .tbl_rd_adr_o(rd_adr[1]),
    .ctrl_key_o(ckey[1]), .ctrl_data_o(cdata[1]), .ctrl_op_o(cop[1]),
    .ctrl_hash_adr_o(chadr[1]), .ctrl_read_data_i(rdata_i[1]),
    .ctrl_no_element_found_i(nf[1]), .ctrl_no_deletion_target_i(nd[1]),
    .ctrl_no_write_space_i(nws[1]), .ctrl_key_already_present_i(kp[1]),
    .resp_valid_o(rvalid[1]), .resp_ready_i(rready[1]),
    .resp_data_o(rdata_o[1]), .resp_status_o(rstat[1]),
    .element_count_o(cnt1)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 request in flight (age = cycles since acceptance),
  // 2 response pending.
  int            lat[2]  = '{1, 3};
  int            cmax[2] = '{255, 7};
  int            m_phase[2];
  int            m_age[2];
  logic          m_ready[2];
  logic          m_acc[2];
  logic [1:0]    m_op[2];
  logic [KW-1:0] m_key[2];
  logic [DW-1:0] m_data[2];
  logic [AW-1:0] m_hash[2];
  logic [2:0]    m_stat[2];
  logic [DW-1:0] m_rdata[2];
  int            m_count[2];

  task automatic model_reset(input int k);
    m_phase[k] = 0; m_age[k] = 0; m_ready[k] = 1'b0; m_acc[k] = 1'b0;
    m_op[k] = '0; m_key[k] = '0; m_data[k] = '0; m_hash[k] = '0;
    m_stat[k] = '0; m_rdata[k] = '0; m_count[k] = 0;
  endtask

  task automatic model_update(input int k);
    m_acc[k] = 1'b0;
    if (rst[k]) begin
      model_reset(k);
      return;
    end
    case (m_phase[k])
      0: begin
        if (m_ready[k] && req_valid[k]) m_acc[k] = 1'b1;
        if (m_acc[k] && req_op[k] != 2'b00) begin
          m_op[k] = req_op[k]; m_key[k] = req_key[k]; m_data[k] = req_data[k];
          m_phase[k] = 1; m_age[k] = 1; m_ready[k] = 1'b0;
        end else begin
          m_ready[k] = 1'b1;
        end
      end
      1: begin
        if (m_age[k] == 1) m_hash[k] = hashf(m_key[k]);
        if (m_age[k] == lat[k] + 1) begin
          if (kp[k])       m_stat[k] = 3'd4;
          else if (nws[k]) m_stat[k] = 3'd3;
          else if (nd[k])  m_stat[k] = 3'd2;
          else if (nf[k])  m_stat[k] = 3'd1;
          else             m_stat[k] = 3'd0;
          m_rdata[k] = (m_op[k] == 2'b01 && !nf[k]) ? rdata_i[k] : '0;
          if (m_stat[k] == 3'd0 && m_op[k] == 2'b10 && m_count[k] < cmax[k]) m_count[k]++;
          if (m_stat[k] == 3'd0 && m_op[k] == 2'b11 && m_count[k] > 0)       m_count[k]--;
          m_phase[k] = 2;
        end else begin
          m_age[k]++;
        end
      end
      default: begin
        if (rready[k]) begin
          m_phase[k] = 0; m_ready[k] = 1'b1;
        end
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] act_cnt(input int k);
    return (k == 0) ? {56'b0, cnt0} : {61'b0, cnt1};
  endfunction

  task automatic check_dut(input int k);
    logic first_rd;
    logic eval;
    first_rd = (m_phase[k] == 1) && (m_age[k] == 1);
    eval     = (m_phase[k] == 1) && (m_age[k] == lat[k] + 1);
    chk($sformatf("d%0d req_ready", k), req_ready[k], m_ready[k]);
    chk($sformatf("d%0d hash_key", k), hkey[k], m_key[k]);
    chk($sformatf("d%0d ctrl_key", k), ckey[k], m_key[k]);
    chk($sformatf("d%0d ctrl_data", k), cdata[k], m_data[k]);
    chk($sformatf("d%0d tbl_rd_en", k), rd_en[k], first_rd);
    chk($sformatf("d%0d tbl_rd_adr", k), rd_adr[k], first_rd ? hashf(m_key[k]) : m_hash[k]);
    chk($sformatf("d%0d ctrl_hash_adr", k), chadr[k], m_hash[k]);
    chk($sformatf("d%0d ctrl_op", k), cop[k], eval ? m_op[k] : 2'b00);
    chk($sformatf("d%0d resp_valid", k), rvalid[k], m_phase[k] == 2);
    chk($sformatf("d%0d resp_data", k), rdata_o[k], m_rdata[k]);
    chk($sformatf("d%0d resp_status", k), rstat[k], m_stat[k]);
    chk($sformatf("d%0d count", k), act_cnt(k), 64'(m_count[k]));
  endtask

  // One clock: model follows the edge, outputs compared half a cycle later.
  task automatic cycle();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic req(input int k, input logic [1:0] op, input logic [KW-1:0] key,
                     input logic [DW-1:0] data);
    int n;
    req_valid[k] = 1'b1; req_op[k] = op; req_key[k] = key; req_data[k] = data;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!m_acc[k] && n < 20);
    checks++;
    if (!m_acc[k]) begin
      failures++;
      $display("FAIL d%0d accept timeout actual=0 required=1", k);
    end
    req_valid[k] = 1'b0;
  endtask

  // Full request with literal expectations at the response cycle.
  task automatic op_run(input int k, input logic [1:0] op, input logic [KW-1:0] key,
                        input logic [DW-1:0] data, input logic [2:0] e_st,
                        input logic [DW-1:0] e_data, input int e_cnt);
    req(k, op, key, data);
    repeat (lat[k] + 1) cycle();
    chk($sformatf("d%0d lit resp_valid", k), rvalid[k], 1'b1);
    chk($sformatf("d%0d lit resp_status", k), rstat[k], e_st);
    chk($sformatf("d%0d lit resp_data", k), rdata_o[k], e_data);
    chk($sformatf("d%0d lit count", k), act_cnt(k), 64'(e_cnt));
    cycle();
    chk($sformatf("d%0d lit resp_done", k), rvalid[k], 1'b0);
  endtask

  task automatic clear_inputs(input int k);
    req_valid[k] = 1'b0; req_op[k] = '0; req_key[k] = '0; req_data[k] = '0;
    rdata_i[k] = '0; nf[k] = 1'b0; nd[k] = 1'b0; nws[k] = 1'b0; kp[k] = 1'b0;
    rready[k] = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      clear_inputs(k);
      rst[k] = 1'b1;
      model_reset(k);
    end
    repeat (3) cycle();
    chk("reset req_ready", req_ready[0], 1'b0);
    chk("reset resp_valid", rvalid[0], 1'b0);
    chk("reset count", act_cnt(0), 64'd0);
    chk("reset hash_key", hkey[0], 2'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // ---- d0 directed (READ_LATENCY=1) ----
    req(0, 2'b10, 2'd2, 32'hDEADBEEF);
    chk("wr rd_en", rd_en[0], 1'b1);
    chk("wr op early", cop[0], 2'b00);
    cycle();
    chk("wr op eval", cop[0], 2'b10);
    cycle();
    chk("wr resp_valid", rvalid[0], 1'b1);
    chk("wr status", rstat[0], 3'b000);
    chk("wr data", rdata_o[0], 32'd0);
    chk("wr count", act_cnt(0), 64'd1);
    chk("wr op late", cop[0], 2'b00);
    cycle();
    chk("wr idle ready", req_ready[0], 1'b1);

    rdata_i[0] = 32'hDEADBEEF;
    op_run(0, 2'b01, 2'd2, 32'd0, 3'b000, 32'hDEADBEEF, 1);
    rdata_i[0] = 32'd0;
    nd[0] = 1'b1;
    op_run(0, 2'b11, 2'd3, 32'd0, 3'b010, 32'd0, 1);
    nd[0] = 1'b0;
    op_run(0, 2'b11, 2'd2, 32'd0, 3'b000, 32'd0, 0);
    op_run(0, 2'b11, 2'd2, 32'd0, 3'b000, 32'd0, 0);
    kp[0] = 1'b1; nws[0] = 1'b1;
    op_run(0, 2'b10, 2'd1, 32'h5, 3'b100, 32'd0, 0);
    kp[0] = 1'b0; nws[0] = 1'b0;

    req(0, 2'b00, 2'd1, 32'h9);
    repeat (3) begin
      chk("nop no resp", rvalid[0], 1'b0);
      chk("nop ready", req_ready[0], 1'b1);
      cycle();
    end

    // Response back-pressure.
    rready[0] = 1'b0;
    req(0, 2'b10, 2'd1, 32'h7);
    repeat (2) cycle();
    req_valid[0] = 1'b1; req_op[0] = 2'b01; req_key[0] = 2'd3;
    repeat (5) begin
      chk("bp resp_valid", rvalid[0], 1'b1);
      chk("bp status", rstat[0], 3'b000);
      chk("bp data", rdata_o[0], 32'd0);
      chk("bp ready", req_ready[0], 1'b0);
      chk("bp count", act_cnt(0), 64'd1);
      cycle();
    end
    req_valid[0] = 1'b0;
    rready[0] = 1'b1;
    cycle();
    chk("bp release valid", rvalid[0], 1'b0);
    chk("bp release ready", req_ready[0], 1'b1);

    // ---- d1 directed (READ_LATENCY=3, 3-bit counter) ----
    req(1, 2'b10, 2'd1, 32'h11);
    chk("rl3 rd_en c1", rd_en[1], 1'b1);
    cycle();
    chk("rl3 rd_en c2", rd_en[1], 1'b0);
    chk("rl3 op c2", cop[1], 2'b00);
    cycle();
    chk("rl3 op c3", cop[1], 2'b00);
    cycle();
    chk("rl3 op eval", cop[1], 2'b10);
    cycle();
    chk("rl3 resp", rvalid[1], 1'b1);
    chk("rl3 count", act_cnt(1), 64'd1);
    cycle();
    for (int i = 0; i < 8; i++) begin
      op_run(1, 2'b10, 2'(i), 32'(i), 3'b000, 32'd0, (i + 2 > 7) ? 7 : i + 2);
    end

    req(1, 2'b10, 2'd2, 32'h22);
    cycle();
    rst[1] = 1'b1;
    cycle();
    chk("mid rst resp_valid", rvalid[1], 1'b0);
    chk("mid rst count", act_cnt(1), 64'd0);
    chk("mid rst hash_key", hkey[1], 2'd0);
    chk("mid rst ctrl_op", cop[1], 2'b00);
    chk("mid rst rd_en", rd_en[1], 1'b0);
    chk("mid rst ready", req_ready[1], 1'b0);
    rst[1] = 1'b0;
    repeat (8) begin
      cycle();
      chk("mid rst no resp", rvalid[1], 1'b0);
    end

    // ---- randomized traffic on both instances ----
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]       = ($urandom_range(0, 299) == 0);
        req_valid[k] = ($urandom_range(0, 1) == 1);
        req_op[k]    = 2'($urandom_range(0, 3));
        req_key[k]   = 2'($urandom_range(0, 3));
        req_data[k]  = $urandom;
        rdata_i[k]   = $urandom;
        nf[k]        = ($urandom_range(0, 3) == 0);
        nd[k]        = ($urandom_range(0, 5) == 0);
        nws[k]       = ($urandom_range(0, 5) == 0);
        kp[k]        = ($urandom_range(0, 5) == 0);
        rready[k]    = ($urandom_range(0, 9) < 6);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
